rc4_ksa_engine: RTL and testbench

//  Parametrised RC4 key-scheduling engine with optional built-in identity fill (S[i]=i).

---
 rtl/rc4_ksa_engine.sv | 169 ++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill followed by the KSA swap loop
// over a single-port synchronous S-box RAM with configurable read latency.
module rc4_ksa_engine #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned MAX_KEY_BYTES = 3,
    parameter int unsigned RD_LAT        = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 init_en,
    input  logic [$clog2(MAX_KEY_BYTES+1)-1:0]   key_len,
    input  logic [MAX_KEY_BYTES*DATA_W-1:0]      key,
    input  logic [DATA_W-1:0]                    ram_rdata,
    output logic [ADDR_W-1:0]                    ram_addr,
    output logic [DATA_W-1:0]                    ram_wdata,
    output logic                                 ram_we,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned         KLEN_W   = $clog2(MAX_KEY_BYTES + 1);
    localparam logic [KLEN_W-1:0]   KLEN_MAX = KLEN_W'(MAX_KEY_BYTES);
    localparam logic [1:0]          LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE, INIT, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE
    } state_t;

    state_t                               state;
    logic [ADDR_W-1:0]                    i;
    logic [ADDR_W-1:0]                    j;
    logic [KLEN_W-1:0]                    kidx;
    logic [KLEN_W-1:0]                    eff_len;
    logic [DATA_W-1:0]                    si;
    logic [1:0]                           lat_cnt;
    logic [MAX_KEY_BYTES-1:0][DATA_W-1:0] key_q;

    logic [DATA_W-1:0]                    key_byte;
    logic [ADDR_W-1:0]                    i_inc;
    logic [ADDR_W-1:0]                    j_next;
    logic [KLEN_W-1:0]                    len_in;

    // Key byte select as a plain mux so kidx never indexes past the key bus
    always_comb begin
        key_byte = '0;
        for (int unsigned k = 0; k < MAX_KEY_BYTES; k++) begin
            if (kidx == KLEN_W'(k)) key_byte = key_q[k];
        end
    end

    assign i_inc  = i + ADDR_W'(1);
    assign j_next = j + ADDR_W'(ram_rdata) + ADDR_W'(key_byte);
    assign len_in = (key_len == '0 || 32'(key_len) > MAX_KEY_BYTES) ? KLEN_MAX : key_len;

    // Outputs are loaded on entry to each state so they are valid for that whole state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            kidx      <= '0;
            eff_len   <= '0;
            si        <= '0;
            lat_cnt   <= '0;
            key_q     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort && state != IDLE) begin
            state  <= IDLE;
            ram_we <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        key_q    <= key;
                        eff_len  <= len_in;
                        i        <= '0;
                        j        <= '0;
                        kidx     <= '0;
                        busy     <= 1'b1;
                        ram_addr <= '0;
                        if (init_en) begin
                            state     <= INIT;
                            ram_wdata <= '0;
                            ram_we    <= 1'b1;
                        end else begin
                            state <= RD_I;
                        end
                    end
                end
                INIT: begin
                    if (&i) begin
                        i        <= '0;
                        ram_addr <= '0;
                        state    <= RD_I;
                    end else begin
                        i         <= i_inc;
                        ram_addr  <= i_inc;
                        ram_wdata <= DATA_W'(i_inc);
                        ram_we    <= 1'b1;
                    end
                end
                RD_I: begin
                    lat_cnt <= '0;
                    state   <= WAIT_I;
                end
                WAIT_I: begin
                    if (lat_cnt == LAT_LAST) begin
                        si       <= ram_rdata;
                        j        <= j_next;
                        ram_addr <= j_next;
                        state    <= RD_J;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RD_J: begin
                    lat_cnt <= '0;
                    state   <= WAIT_J;
                end
                WAIT_J: begin
                    if (lat_cnt == LAT_LAST) begin
                        ram_addr  <= i;
                        ram_wdata <= ram_rdata;
                        ram_we    <= 1'b1;
                        state     <= WR_I;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                WR_I: begin
                    ram_addr  <= j;
                    ram_wdata <= si;
                    ram_we    <= 1'b1;
                    state     <= WR_J;
                end
                WR_J: begin
                    kidx <= (kidx == eff_len - KLEN_W'(1)) ? '0 : kidx + KLEN_W'(1);
                    if (&i) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        i        <= i_inc;
                        ram_addr <= i_inc;
                        state    <= RD_I;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Directed bench for rc4_ksa_engine: three parameterisations, each with its own
// behavioural S-box RAM; results checked against hand values and a KSA model.
module tb_rc4_ksa_engine;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, init_en;
    logic [1:0]  sel;
    logic [2:0]  key_len;
    logic [31:0] key;
    logic        preload_c, mon_en, mon_clr;

    int errors = 0;
    int checks = 0;

    // DUT A: 2-bit S-box, RD_LAT=1
    logic [1:0] a_addr, a_wdata, a_rdata;
    logic       a_we, a_busy, a_done;
    logic [1:0] mem_a [4];

    rc4_ksa_engine #(.DATA_W(2), .ADDR_W(2), .MAX_KEY_BYTES(1), .RD_LAT(1)) u_a (
        .clk(clk), .reset(reset), .start(start && sel == 2'd0), .abort(abort && sel == 2'd0),
        .init_en(init_en), .key_len(key_len[0:0]), .key(key[1:0]), .ram_rdata(a_rdata),
        .ram_addr(a_addr), .ram_wdata(a_wdata), .ram_we(a_we), .busy(a_busy), .done(a_done)
    );

    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= a_wdata;
        a_rdata <= mem_a[a_addr];
    end

    // DUT B: default parameters
    logic [7:0] b_addr, b_wdata, b_rdata;
    logic       b_we, b_busy, b_done;
    logic [7:0] mem_b [256];

    rc4_ksa_engine u_b (
        .clk(clk), .reset(reset), .start(start && sel == 2'd1), .abort(abort && sel == 2'd1),
        .init_en(init_en), .key_len(key_len[1:0]), .key(key[23:0]), .ram_rdata(b_rdata),
        .ram_addr(b_addr), .ram_wdata(b_wdata), .ram_we(b_we), .busy(b_busy), .done(b_done)
    );

    always @(posedge clk) begin
        if (b_we) mem_b[b_addr] <= b_wdata;
        b_rdata <= mem_b[b_addr];
    end

    // DUT C: 4-byte key bus, RD_LAT=3
    logic [7:0] c_addr, c_wdata, c_rdata, c_p1, c_p2;
    logic       c_we, c_busy, c_done;
    logic [7:0] mem_c [256];

    rc4_ksa_engine #(.DATA_W(8), .ADDR_W(8), .MAX_KEY_BYTES(4), .RD_LAT(3)) u_c (
        .clk(clk), .reset(reset), .start(start && sel == 2'd2), .abort(abort && sel == 2'd2),
        .init_en(init_en), .key_len(key_len), .key(key), .ram_rdata(c_rdata),
        .ram_addr(c_addr), .ram_wdata(c_wdata), .ram_we(c_we), .busy(c_busy), .done(c_done)
    );

    always @(posedge clk) begin
        if (preload_c) begin
            for (int k = 0; k < 256; k++) mem_c[k] <= 8'(k);
        end else if (c_we) begin
            mem_c[c_addr] <= c_wdata;
        end
        c_p1    <= mem_c[c_addr];
        c_p2    <= c_p1;
        c_rdata <= c_p2;
    end

    // WR_J spacing monitor for DUT C (second write of each back-to-back pair)
    int   cyc = 0, wrj_n = 0, wrj_bad = 0, wrj_last = -1;
    logic c_we_d = 1'b0;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        c_we_d <= c_we;
        if (mon_clr) begin
            wrj_n    <= 0;
            wrj_bad  <= 0;
            wrj_last <= -1;
        end else if (mon_en && c_we && c_we_d) begin
            wrj_n <= wrj_n + 1;
            if (wrj_last >= 0 && cyc - wrj_last != 10) wrj_bad <= wrj_bad + 1;
            wrj_last <= cyc;
        end
    end

    logic s_busy, s_done, s_we;
    assign s_busy = (sel == 2'd0) ? a_busy : (sel == 2'd1) ? b_busy : c_busy;
    assign s_done = (sel == 2'd0) ? a_done : (sel == 2'd1) ? b_done : c_done;
    assign s_we   = (sel == 2'd0) ? a_we   : (sel == 2'd1) ? b_we   : c_we;

    logic [7:0] exp_s [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference RC4 KSA starting from the identity permutation
    task automatic ksa_model(input int klen, input logic [31:0] k);
        int         jj;
        logic [7:0] t, kb;
        jj = 0;
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            kb = k[8*(n % klen) +: 8];
            jj = (jj + int'(exp_s[n]) + int'(kb)) % 256;
            t         = exp_s[n];
            exp_s[n]  = exp_s[jj];
            exp_s[jj] = t;
        end
    endtask

    function automatic int ram_diff(input int d);
        int c = 0;
        for (int n = 0; n < 256; n++) begin
            if (d == 1 && mem_b[n] !== exp_s[n]) c++;
            if (d == 2 && mem_c[n] !== exp_s[n]) c++;
        end
        return c;
    endfunction

    function automatic int perm_b();
        logic [255:0] seen = '0;
        for (int n = 0; n < 256; n++) seen[mem_b[n]] = 1'b1;
        return $countones(seen);
    endfunction

    // Start a run, scramble the inputs afterwards, time busy-rise to done
    task automatic run(input int d, input logic ie, input logic [2:0] kl, input logic [31:0] k,
                       input int exp_cyc, input string tag);
        int n;
        @(negedge clk);
        sel = 2'(d); init_en = ie; key_len = kl; key = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0; key = ~k; key_len = kl ^ 3'd1; init_en = ~ie;
        chk({tag, "_busy"}, 32'(s_busy), 32'd1);
        n = 0;
        while (!s_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cycles"}, n, exp_cyc);
        chk({tag, "_done_busy"}, 32'(s_busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {30'd0, s_done, s_busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        reset = 1'b1; start = 1'b0; abort = 1'b0; init_en = 1'b0; sel = 2'd0;
        key_len = '0; key = '0; preload_c = 1'b0; mon_en = 1'b0; mon_clr = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(b_busy), 32'd0);
        chk("rst_done", 32'(b_done), 32'd0);
        chk("rst_we", 32'(b_we), 32'd0);
        chk("rst_addr", 32'(b_addr), 32'd0);
        chk("rst_wdata", 32'(b_wdata), 32'd0);
        chk("rst_c_busy", {30'd0, c_busy, c_we}, 32'd0);
        reset = 1'b0;

        // 2-bit S-box, zero key: [0,2,3,1] in 4+4*6 cycles
        run(0, 1'b1, 3'd1, 32'd0, 28, "a");
        chk("a_s0", 32'(mem_a[0]), 32'd0);
        chk("a_s1", 32'(mem_a[1]), 32'd2);
        chk("a_s2", 32'(mem_a[2]), 32'd3);
        chk("a_s3", 32'(mem_a[3]), 32'd1);

        // Default params, key 01 02 03
        ksa_model(3, 32'h00030201);
        run(1, 1'b1, 3'd3, 32'h00030201, 1792, "b");
        chk("b_ram", ram_diff(1), 0);
        chk("b_perm", perm_b(), 256);

        // RD_LAT=3, no fill, identity preloaded; key[3]=FF unused with key_len=3
        @(negedge clk); preload_c = 1'b1;
        @(negedge clk); preload_c = 1'b0; mon_clr = 1'b0; mon_en = 1'b1;
        run(2, 1'b0, 3'd3, 32'hFF030201, 2560, "c3");
        mon_en = 1'b0;
        chk("c3_ram", ram_diff(2), 0);
        chk("c3_wrj_n", wrj_n, 256);
        chk("c3_wrj_spacing", wrj_bad, 0);

        ksa_model(4, 32'h04030201);
        run(2, 1'b1, 3'd0, 32'h04030201, 2816, "c0");
        chk("c0_ram", ram_diff(2), 0);
        run(2, 1'b1, 3'd7, 32'h04030201, 2816, "c7");
        chk("c7_ram", ram_diff(2), 0);
        ksa_model(2, 32'h0000A55A);
        run(2, 1'b1, 3'd2, 32'h1234A55A, 2816, "c2");
        chk("c2_ram", ram_diff(2), 0);

        // Start pulse while busy must not restart the fill; then abort mid-shuffle
        @(negedge clk);
        sel = 2'd1; init_en = 1'b1; key_len = 3'd3; key = 32'h00030201; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 49; n++) @(negedge clk);
        chk("ab_addr49", 32'(b_addr), 32'd49);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ab_addr50", 32'(b_addr), 32'd50);
        @(negedge clk);
        chk("ab_addr51", 32'(b_addr), 32'd51);
        chk("ab_busy", 32'(b_busy), 32'd1);
        for (n = 51; n < 600; n++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_idle", {29'd0, b_busy, b_we, b_done}, 32'd0);
        bad = 0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b_done || b_we || b_busy) bad++;
        end
        chk("ab_quiet", bad, 0);
        ksa_model(3, 32'h00030201);
        run(1, 1'b1, 3'd3, 32'h00030201, 1792, "ab_rerun");
        chk("ab_rerun_ram", ram_diff(1), 0);

        // Asynchronous reset at cycle 100 of a run
        @(negedge clk);
        sel = 2'd1; init_en = 1'b1; key_len = 3'd3; key = 32'h00030201; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 100; n++) @(negedge clk);
        chk("rr_we_before", 32'(b_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rr_we", 32'(b_we), 32'd0);
        chk("rr_busy", 32'(b_busy), 32'd0);
        chk("rr_addr", 32'(b_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rr_after", {30'd0, b_we, b_busy}, 32'd0);
        run(1, 1'b1, 3'd3, 32'h00030201, 1792, "rr_rerun");
        chk("rr_rerun_ram", ram_diff(1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
